// File: rtl/song_player_if.sv
// Control and status bundle between a song source/controller and song_player.
// The controller drives the song and transport pulses; the player reports progress.
interface song_player_if #(
  parameter int NUM_NOTES = 28,
  parameter int NOTE_W    = 4
);
  logic [NUM_NOTES*NOTE_W-1:0] song_packed;
  logic                        play;
  logic                        pause;
  logic                        stop;
  logic                        loop_en;
  logic [NOTE_W-1:0]           note_code;
  logic [4:0]                  note_idx;
  logic                        speaker;
  logic                        playing;
  logic                        done;

  modport master (
    output song_packed, play, pause, stop, loop_en,
    input  note_code, note_idx, speaker, playing, done
  );

  modport slave (
    input  song_packed, play, pause, stop, loop_en,
    output note_code, note_idx, speaker, playing, done
  );
endinterface

// File: rtl/song_player.sv
// Note sequencer: steps through a latched packed song, one beat per note slot,
// driving a square-wave tone during the note and silence during the trailing gap.
//
// state    | meaning
// S_IDLE   | stopped, speaker low, waiting for play
// S_NOTE   | tone portion of the current slot
// S_GAP    | silent tail of the current slot
// S_PAUSED | frozen; beat_cnt tells whether to resume into NOTE or GAP
module song_player #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BEAT_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int NUM_NOTES   = 28,
  parameter int NOTE_W      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  song_player_if.slave bus
);
  localparam int BW = $clog2(BEAT_CYCLES + 1);
  localparam int SW = NUM_NOTES * NOTE_W;
  localparam logic [BW-1:0] TONE_LAST = BW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BW-1:0] SLOT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [4:0]    IDX_LAST  = 5'(NUM_NOTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP, S_PAUSED} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]       tone_cnt_q, tone_cnt_d;
  logic [NOTE_W-1:0] note_code_q, note_code_d;
  logic [4:0]        note_idx_q, note_idx_d;
  logic              speaker_q, speaker_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;

  logic              slot_end;
  logic              last_note;
  logic [4:0]        next_idx;
  logic [31:0]       half;

  function automatic logic [31:0] half_period(input logic [NOTE_W-1:0] code);
    case (int'(code))
      1:       half_period = 32'(CLK_FREQ / (2 * 262));
      2:       half_period = 32'(CLK_FREQ / (2 * 294));
      3:       half_period = 32'(CLK_FREQ / (2 * 330));
      4:       half_period = 32'(CLK_FREQ / (2 * 349));
      5:       half_period = 32'(CLK_FREQ / (2 * 392));
      6:       half_period = 32'(CLK_FREQ / (2 * 440));
      7:       half_period = 32'(CLK_FREQ / (2 * 494));
      default: half_period = '0;
    endcase
  endfunction

  assign slot_end  = (beat_cnt_q == SLOT_LAST);
  assign last_note = (note_idx_q == IDX_LAST);
  assign next_idx  = last_note ? 5'd0 : note_idx_q + 5'd1;
  assign half      = half_period(note_code_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.stop && bus.play) state_d = S_NOTE;
      S_NOTE: begin
        if (bus.stop)                     state_d = S_IDLE;
        else if (bus.pause)               state_d = S_PAUSED;
        else if (beat_cnt_q == TONE_LAST) state_d = S_GAP;
      end
      S_GAP: begin
        if (bus.stop)                                 state_d = S_IDLE;
        else if (bus.pause)                           state_d = S_PAUSED;
        else if (slot_end && last_note && !bus.loop_en) state_d = S_IDLE;
        else if (slot_end)                            state_d = S_NOTE;
      end
      S_PAUSED: begin
        // beat_cnt is frozen, so its position in the slot recalls NOTE vs GAP
        if (bus.stop)      state_d = S_IDLE;
        else if (bus.play) state_d = (beat_cnt_q > TONE_LAST) ? S_GAP : S_NOTE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d    = shadow_q;
    beat_cnt_d  = beat_cnt_q;
    tone_cnt_d  = tone_cnt_q;
    note_code_d = note_code_q;
    note_idx_d  = note_idx_q;
    speaker_d   = 1'b0;
    done_d      = 1'b0;
    playing_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (state_d == S_NOTE) begin
          shadow_d    = bus.song_packed;
          beat_cnt_d  = '0;
          tone_cnt_d  = '0;
          note_idx_d  = 5'd0;
          note_code_d = bus.song_packed[NOTE_W-1:0];
        end
      end
      S_NOTE: begin
        if (state_d == S_NOTE || state_d == S_GAP) beat_cnt_d = beat_cnt_q + 1'b1;
        if (state_d == S_NOTE && half != 32'd0) begin
          if (tone_cnt_q == half - 32'd1) begin
            tone_cnt_d = '0;
            speaker_d  = ~speaker_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 32'd1;
            speaker_d  = speaker_q;
          end
        end
      end
      S_GAP: begin
        if (state_d == S_GAP) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (state_d == S_NOTE) begin
          beat_cnt_d  = '0;
          tone_cnt_d  = '0;
          note_idx_d  = next_idx;
          note_code_d = shadow_q[int'(next_idx)*NOTE_W +: NOTE_W];
        end else if (state_d == S_IDLE && !bus.stop) begin
          done_d = 1'b1;
        end
      end
      S_PAUSED: begin
        if (state_d == S_NOTE || state_d == S_GAP) tone_cnt_d = '0;
      end
      default: ;
    endcase
    if (state_d == S_IDLE) begin
      note_code_d = '0;
      note_idx_d  = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      beat_cnt_q  <= '0;
      tone_cnt_q  <= '0;
      note_code_q <= '0;
      note_idx_q  <= 5'd0;
      speaker_q   <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      beat_cnt_q  <= beat_cnt_d;
      tone_cnt_q  <= tone_cnt_d;
      note_code_q <= note_code_d;
      note_idx_q  <= note_idx_d;
      speaker_q   <= speaker_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  assign bus.note_code = note_code_q;
  assign bus.note_idx  = note_idx_q;
  assign bus.speaker   = speaker_q;
  assign bus.playing   = playing_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_song_player.sv
// Directed/random bench for song_player: two instances (short and long beat) checked
// cycle by cycle against a slot/tone arithmetic model of the player.
module tb_song_player;
  localparam int NN  = 28;
  localparam int NW  = 4;
  localparam int CF  = 52400;
  localparam int GAP = 4;
  localparam int BA  = 20;
  localparam int BB  = 400;
  localparam int SW  = NN * NW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  song_player_if #(.NUM_NOTES(NN), .NOTE_W(NW)) ifa ();
  song_player_if #(.NUM_NOTES(NN), .NOTE_W(NW)) ifb ();

  song_player #(.CLK_FREQ(CF), .BEAT_CYCLES(BA), .GAP_CYCLES(GAP), .NUM_NOTES(NN), .NOTE_W(NW))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  song_player #(.CLK_FREQ(CF), .BEAT_CYCLES(BB), .GAP_CYCLES(GAP), .NUM_NOTES(NN), .NOTE_W(NW))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  function automatic int note_of(input logic [SW-1:0] song, input int i);
    logic [SW-1:0] t;
    t = song >> (i * NW);
    return int'(t[NW-1:0]);
  endfunction

  function automatic int half_of(input int code);
    case (code)
      1: return CF / (2 * 262);
      2: return CF / (2 * 294);
      3: return CF / (2 * 330);
      4: return CF / (2 * 349);
      5: return CF / (2 * 392);
      6: return CF / (2 * 440);
      7: return CF / (2 * 494);
      default: return 0;
    endcase
  endfunction

  // t = cycles since the tone last restarted, s = position within the slot
  function automatic int exp_spk(input int code, input int t, input int s, input int beat);
    int h;
    h = half_of(code);
    if (s >= beat - GAP || h == 0) return 0;
    return (t / h) % 2;
  endfunction

  function automatic logic [SW-1:0] rand_song();
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < NN; i++) r[i*NW +: NW] = NW'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int idx, input int code, input int spk,
                       input int ply, input int dn);
    chk({tag, ".note_idx"},  32'(ifa.note_idx),  idx);
    chk({tag, ".note_code"}, 32'(ifa.note_code), code);
    chk({tag, ".speaker"},   32'(ifa.speaker),   spk);
    chk({tag, ".playing"},   32'(ifa.playing),   ply);
    chk({tag, ".done"},      32'(ifa.done),      dn);
  endtask

  task automatic chk_b(input string tag, input int idx, input int code, input int spk,
                       input int ply, input int dn);
    chk({tag, ".note_idx"},  32'(ifb.note_idx),  idx);
    chk({tag, ".note_code"}, 32'(ifb.note_code), code);
    chk({tag, ".speaker"},   32'(ifb.speaker),   spk);
    chk({tag, ".playing"},   32'(ifb.playing),   ply);
    chk({tag, ".done"},      32'(ifb.done),      dn);
  endtask

  initial begin
    int twk[NN] = '{1,1,5,5,6,6,5,4,4,3,3,2,2,1,5,5,4,4,3,3,2,5,5,4,4,3,3,2};
    logic [SW-1:0] song;
    int i, s, c, tt;

    ifa.song_packed = '0; ifa.play = 0; ifa.pause = 0; ifa.stop = 0; ifa.loop_en = 0;
    ifb.song_packed = '0; ifb.play = 0; ifb.pause = 0; ifb.stop = 0; ifb.loop_en = 0;

    // reset
    repeat (3) @(negedge clk);
    chk_a("reset_a", 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_a("idle_a", 0, 0, 0, 0, 0);

    // full non-looped twinkle song; a stray play mid-song must be ignored
    song = '0;
    for (int k = 0; k < NN; k++) song[k*NW +: NW] = NW'(twk[k]);
    ifa.song_packed = song;
    ifa.play = 1;
    @(negedge clk);
    ifa.play = 0;
    for (int k = 0; k < NN * BA; k++) begin
      i = k / BA; s = k % BA; c = note_of(song, i);
      chk_a("twinkle", i, c, exp_spk(c, s, s, BA), 1, 0);
      ifa.play = (k == 50);
      @(negedge clk);
    end
    chk_a("twinkle_done", 0, 0, 0, 0, 1);
    @(negedge clk);
    chk_a("twinkle_after", 0, 0, 0, 0, 0);

    // long beat: tone timing, then rests 0, 8, 15, then code 1
    song = rand_song();
    song[0 +: NW] = 4'd6; song[NW +: NW] = 4'd0; song[2*NW +: NW] = 4'd8;
    song[3*NW +: NW] = 4'd15; song[4*NW +: NW] = 4'd1;
    ifb.song_packed = song;
    ifb.play = 1;
    @(negedge clk);
    ifb.play = 0;
    for (int k = 0; k < 5 * BB; k++) begin
      i = k / BB; s = k % BB; c = note_of(song, i);
      chk_b("tone", i, c, exp_spk(c, s, s, BB), 1, 0);
      @(negedge clk);
    end
    ifb.stop = 1;
    @(negedge clk);
    ifb.stop = 0;
    chk_b("tone_stop", 0, 0, 0, 0, 0);

    // pause at beat 7 then resume: 13 cycles left in the slot
    song = rand_song();
    ifa.song_packed = song;
    ifa.play = 1;
    @(negedge clk);
    ifa.play = 0;
    for (int k = 0; k < 8; k++) begin
      chk_a("pre_pause", 0, note_of(song, 0), 0, 1, 0);
      ifa.pause = (k == 7);
      @(negedge clk);
    end
    ifa.pause = 0;
    for (int j = 0; j < 30; j++) begin
      chk_a("paused", 0, note_of(song, 0), 0, 1, 0);
      ifa.play = (j == 29);
      @(negedge clk);
    end
    ifa.play = 0;
    for (int j = 0; j < 16; j++) begin
      s = 7 + j; i = s / BA;
      chk_a("resume", i, note_of(song, i), 0, 1, 0);
      @(negedge clk);
    end
    ifa.stop = 1;
    @(negedge clk);
    ifa.stop = 0;
    chk_a("stop_paused", 0, 0, 0, 0, 0);

    // pause mid-tone on the long beat: speaker low while paused, tone restarts on resume
    song = rand_song();
    song[0 +: NW] = 4'd6; song[NW +: NW] = 4'd1;
    ifb.song_packed = song;
    ifb.play = 1;
    @(negedge clk);
    ifb.play = 0;
    for (int k = 0; k < 100; k++) begin
      chk_b("pre_pause_b", 0, 6, exp_spk(6, k, k, BB), 1, 0);
      ifb.pause = (k == 99);
      @(negedge clk);
    end
    ifb.pause = 0;
    for (int j = 0; j < 20; j++) begin
      chk_b("paused_b", 0, 6, 0, 1, 0);
      ifb.play = (j == 19);
      @(negedge clk);
    end
    ifb.play = 0;
    for (int j = 0; j < 320; j++) begin
      s = 99 + j; i = s / BB; c = note_of(song, i);
      tt = (i == 0) ? j : s % BB;
      chk_b("resume_b", i, c, exp_spk(c, tt, s % BB, BB), 1, 0);
      @(negedge clk);
    end
    ifb.stop = 1;
    @(negedge clk);
    ifb.stop = 0;
    chk_b("stop_b", 0, 0, 0, 0, 0);

    // stop at note 10: no done afterwards; stop beats play in IDLE; pause ignored in IDLE
    song = rand_song();
    ifa.song_packed = song;
    ifa.play = 1;
    @(negedge clk);
    ifa.play = 0;
    for (int k = 0; k < 205; k++) begin
      i = k / BA;
      chk_a("to_stop", i, note_of(song, i), 0, 1, 0);
      ifa.stop = (k == 204);
      @(negedge clk);
    end
    ifa.stop = 0;
    for (int k = 0; k < 400; k++) begin
      chk_a("stopped", 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    ifa.stop = 1; ifa.play = 1;
    @(negedge clk);
    ifa.stop = 0; ifa.play = 0;
    chk_a("stop_play", 0, 0, 0, 0, 0);
    ifa.pause = 1;
    @(negedge clk);
    ifa.pause = 0;
    chk_a("pause_idle", 0, 0, 0, 0, 0);

    // loop mode, with song_packed rewritten mid-song
    song = rand_song();
    ifa.song_packed = song;
    ifa.loop_en = 1;
    ifa.play = 1;
    @(negedge clk);
    ifa.play = 0;
    for (int k = 0; k < NN * BA + 60; k++) begin
      i = (k % (NN * BA)) / BA;
      chk_a("loop", i, note_of(song, i), 0, 1, 0);
      if (k == 100) ifa.song_packed = ~song;
      @(negedge clk);
    end
    ifa.loop_en = 0;
    ifa.stop = 1;
    @(negedge clk);
    ifa.stop = 0;
    chk_a("loop_stop", 0, 0, 0, 0, 0);

    // reset mid-song overrides a concurrent play
    ifa.song_packed = rand_song();
    ifa.play = 1;
    @(negedge clk);
    ifa.play = 0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0; ifa.play = 1;
    @(negedge clk);
    chk_a("mid_reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1; ifa.play = 0;
    @(negedge clk);
    chk_a("post_reset", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
